// File: rtl/mix_columns_iter.sv
// Iterative AES-128 MixColumns: one 32-bit column per clock through a shared GF(2^8) multiplier bank.
// Define MIX_COLUMNS_ITER_INV_MIX_EN to add InvMixColumns, selected by mode latched at accept.
module mix_columns_iter #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [127:0]  data_r;
  logic [127:0]  data_next_s;
  logic [127:0]  data_wb_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          accept_s;
  logic          release_s;
  logic          last_s;

  logic [31:0]   col_s;
  logic [31:0]   fwd_col_s;
  logic [31:0]   new_col_s;
  logic [7:0]    a_s  [4];
  logic [7:0]    m2_s [4];
  logic [7:0]    m3_s [4];

  assign accept_s  = (state_r == IDLE) && in_valid && in_ready_r;
  assign release_s = (state_r == DONE) && out_valid_r && out_ready;
  assign last_s    = (cnt_r == CW'(NCOL - 1));

  // Column mux: selects the column addressed by the counter
  always_comb begin
    col_s = 32'h0000_0000;
    case (cnt_r)
      CW'(0):  col_s = data_r[127:96];
      CW'(1):  col_s = data_r[95:64];
      CW'(2):  col_s = data_r[63:32];
      CW'(3):  col_s = data_r[31:0];
      default: col_s = 32'h0000_0000;
    endcase
  end

  // Shared multiplier bank: 2x and 3x of each byte of the selected column
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_s[i]  = col_s[31-8*i -: 8];
      m2_s[i] = xtime(a_s[i]);
      m3_s[i] = m2_s[i] ^ a_s[i];
    end
  end

  // Forward MixColumns matrix row combination
  always_comb begin
    fwd_col_s[31:24] = m2_s[0] ^ m3_s[1] ^ a_s[2]  ^ a_s[3];
    fwd_col_s[23:16] = a_s[0]  ^ m2_s[1] ^ m3_s[2] ^ a_s[3];
    fwd_col_s[15:8]  = a_s[0]  ^ a_s[1]  ^ m2_s[2] ^ m3_s[3];
    fwd_col_s[7:0]   = m3_s[0] ^ a_s[1]  ^ a_s[2]  ^ m2_s[3];
  end

`ifdef MIX_COLUMNS_ITER_INV_MIX_EN
  logic          mode_r;
  logic [31:0]   inv_col_s;
  logic [7:0]    m4_s [4];
  logic [7:0]    m8_s [4];
  logic [7:0]    m9_s [4];
  logic [7:0]    mb_s [4];
  logic [7:0]    md_s [4];
  logic [7:0]    me_s [4];

  // Inverse coefficients built by extending the xtime chain of the shared bank
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m4_s[i] = xtime(m2_s[i]);
      m8_s[i] = xtime(m4_s[i]);
      m9_s[i] = m8_s[i] ^ a_s[i];
      mb_s[i] = m8_s[i] ^ m2_s[i] ^ a_s[i];
      md_s[i] = m8_s[i] ^ m4_s[i] ^ a_s[i];
      me_s[i] = m8_s[i] ^ m4_s[i] ^ m2_s[i];
    end
  end

  // InvMixColumns matrix row combination
  always_comb begin
    inv_col_s[31:24] = me_s[0] ^ mb_s[1] ^ md_s[2] ^ m9_s[3];
    inv_col_s[23:16] = m9_s[0] ^ me_s[1] ^ mb_s[2] ^ md_s[3];
    inv_col_s[15:8]  = md_s[0] ^ m9_s[1] ^ me_s[2] ^ mb_s[3];
    inv_col_s[7:0]   = mb_s[0] ^ md_s[1] ^ m9_s[2] ^ me_s[3];
  end

  assign new_col_s = mode_r ? inv_col_s : fwd_col_s;

  // Direction is captured with the state so it cannot change mid-operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else if (accept_s) begin
      mode_r <= mode;
    end else begin
      mode_r <= mode_r;
    end
  end
`else
  logic mode_unused_s;

  assign mode_unused_s = mode;
  assign new_col_s     = fwd_col_s;
`endif

  // Write-back: replace the addressed column, leave the others untouched
  always_comb begin
    data_wb_s = data_r;
    case (cnt_r)
      CW'(0):  data_wb_s[127:96] = new_col_s;
      CW'(1):  data_wb_s[95:64]  = new_col_s;
      CW'(2):  data_wb_s[63:32]  = new_col_s;
      CW'(3):  data_wb_s[31:0]   = new_col_s;
      default: data_wb_s         = data_r;
    endcase
  end

  // Next-state, counter and state-register update
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    data_next_s  = data_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = BUSY;
          cnt_next_s   = {CW{1'b0}};
          data_next_s  = data_in;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        data_next_s = data_wb_s;
        if (last_s) begin
          state_next_s = DONE;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = BUSY;
          cnt_next_s   = cnt_r + CW'(1);
        end
      end
      DONE: begin
        if (release_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Handshake flags are registered from the next state so they stay low during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      data_r      <= 128'h0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      data_r      <= data_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign data_out  = data_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed self-checking bench for mix_columns_iter using FIPS-197 vectors.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] V1 = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] R1 = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] R2 = 128'h046681e5e0cb199a48f8d37a2806264c;
  // Forward MixColumns of R1, worked by hand
  localparam logic [127:0] R1F = 128'hcd5045069f494f1f01010101c6c6c6c6;

  always #5 clk = ~clk;

  mix_columns_iter #(.NCOL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  task automatic check1(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
  task automatic run_vec(input string tag, input logic [127:0] din, input logic m,
                         input logic [127:0] exp);
    int n;
    check1({tag, " ready_before"}, 128'(in_ready), 128'(1'b1));
    data_in   = din;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 128'h0;
    mode     = 1'b0;
    check1({tag, " busy_ready"}, 128'(in_ready), 128'(1'b0));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1({tag, " latency"}, 128'(n), 128'(4));
    check1({tag, " data"}, data_out, exp);
    @(negedge clk);
    check1({tag, " valid_after"}, 128'(out_valid), 128'(1'b0));
    check1({tag, " ready_after"}, 128'(in_ready), 128'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    data_in   = 128'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst out_valid", 128'(out_valid), 128'(1'b0));
    check1("rst in_ready", 128'(in_ready), 128'(1'b0));
    check1("rst data_out", data_out, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst in_ready", 128'(in_ready), 128'(1'b1));
    check1("post_rst out_valid", 128'(out_valid), 128'(1'b0));

    // FIPS-197 vectors
    run_vec("fips", V1, 1'b0, R1);
    run_vec("round1", V2, 1'b0, R2);

    // Backpressure
    out_ready = 1'b0;
    data_in   = V1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 128'h0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("bp latency", 128'(n), 128'(4));
    check1("bp data", data_out, R1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("bp hold data", data_out, R1);
      check1("bp hold ready", 128'(in_ready), 128'(1'b0));
      check1("bp hold valid", 128'(out_valid), 128'(1'b1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp release valid", 128'(out_valid), 128'(1'b0));
    check1("bp release ready", 128'(in_ready), 128'(1'b1));

    // Back-to-back with in_valid held high
    data_in  = V1;
    in_valid = 1'b1;
    @(negedge clk);
    data_in = V2;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("b2b first latency", 128'(n), 128'(4));
    check1("b2b first data", data_out, R1);
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check1("b2b spacing", 128'(n), 128'(6));
    check1("b2b second data", data_out, R2);
    @(negedge clk);
    check1("b2b final ready", 128'(in_ready), 128'(1'b1));

    // Reset mid-operation
    data_in  = V2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("midrst out_valid", 128'(out_valid), 128'(1'b0));
    check1("midrst data_out", data_out, 128'h0);
    check1("midrst in_ready", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("after_rst", V1, 1'b0, R1);

    // mode = 1: inverse when enabled, otherwise forward
`ifdef MIX_COLUMNS_ITER_INV_MIX_EN
    run_vec("inv", R1, 1'b1, V1);
`else
    run_vec("mode_ignored", R1, 1'b1, R1F);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative AES-128 MixColumns stage: accepts one 128-bit state after ShiftRows and returns the MixColumns result.
- Processes one 32-bit column per clock, reusing a single bank of four multi_2/multi_3 GF(2^8) multiplier pairs.
- Sits between the ShiftRows stage and AddRoundKey in the round datapath.
- Uses a valid/ready handshake on both sides so round control can stall it.

Parameters:
- NCOL, 4, number of columns per state. Fixed at 4 for AES; the counter width is derived from it.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream state is valid.
- in_ready  output  1  block can accept a state.
- data_in  input  128  state; byte 0 = [127:120]; column c = bits [127-32c -: 32], row 0 in the MSB byte.
- mode  input  1  0 = MixColumns, 1 = InvMixColumns. Only used with INV_MIX_EN; ignored otherwise.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- data_out  output  128  result, same byte ordering as data_in.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE and the column counter to 0.
  - The state register clears to 0, so data_out = 0.
  - out_valid = 0 and in_ready = 0 while rst_n is low; in_ready = 1 in the first cycle after release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: capture data_in into the state register, latch mode, clear the counter, go to BUSY.
- BUSY:
  - in_ready = 0 and out_valid = 0.
  - Each edge replaces column[cnt] of the state register with its transformed column, then increments cnt.
  - When cnt == NCOL-1 that edge writes column 3 and the FSM goes to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - data_out holds stable until out_valid && out_ready; the FSM then returns to IDLE.
  - No same-cycle input bypass: a new state is accepted earliest one cycle after output handshake.
- Latency: accept edge E0; columns 0..3 written on E1..E4; out_valid high from E4.
  - With out_ready held high, the output handshake occurs on E5.
  - Throughput is one state per 6 cycles.
- Forward column math (a0..a3 → b0..b3, all GF(2^8), XOR addition):
  - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - 2x is xtime with reduction polynomial 0x11B; 3x = 2x ^ x.
- Column mux: the column mux output feeds the shared multiplier bank. The write-back is purely combinational from the registered state; no extra pipeline register.
- in_valid while not IDLE is ignored. Upstream must hold data_in until in_ready.
- out_ready while not DONE has no effect.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. The partial result is discarded and the register clears.

Optional Feature:
- Macro: MIX_COLUMNS_ITER_INV_MIX_EN.
- Defined:
  - mode is latched at accept.
  - mode = 1 applies InvMixColumns with matrix rows {0e,0b,0d,09} rotated per row.
  - The inverse coefficients are built from xtime chains: 4x = 2(2x), 8x = 2(4x); 9 = 8^1, 0b = 8^2^1, 0d = 8^4^1, 0e = 8^4^2.
  - Timing and handshake are identical to forward mode.
- Undefined:
  - mode is ignored and the inverse logic is not synthesised.
  - Forward MixColumns only.

Test Plan:
1. FIPS-197 vector: data_in = db135345f20a225c01010101c6c6c6c6, in_valid pulse, out_ready = 1 → out_valid rises 4 edges after accept; data_out = 8e4da1bc9fdc589d01010101c6c6c6c6.
2. Round-1 column vector: d4bf5d30e0b452aeb84111f11e2798e5 → 046681e5e0cb199a48f8d37a2806264c.
3. Backpressure: hold out_ready = 0 for 10 cycles after out_valid → data_out stable, in_ready = 0 throughout; raise out_ready → IDLE next cycle, in_ready = 1.
4. Back-to-back: in_valid held high with two vectors (tests 1 and 2), out_ready = 1 → both correct, in order, 6 cycles apart; second not captured while BUSY/DONE.
5. Reset mid-operation: assert rst_n = 0 two cycles after accept → immediately out_valid = 0, data_out = 0; after release in_ready = 1 and a fresh vector completes correctly.
6. With MIX_COLUMNS_ITER_INV_MIX_EN and mode = 1: data_in = 8e4da1bc9fdc589d01010101c6c6c6c6 → data_out = db135345f20a225c01010101c6c6c6c6. Without the macro, the same stimulus with mode = 1 yields the forward result.
